// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_KILL = 2'd2
    } state_e;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam int   ALIGN_BITS   = 2;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Redirect detection, target select with word alignment, and sequential PC increment.
module fetch_sequencer_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              flush_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic [ADDR_W-1:0] cur_addr_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] target_o,
    output logic [ADDR_W-1:0] seq_o
);

    always_comb begin
        redirect_o = flush_i | branch_flag_i;
        // Flush wins over a branch in the same cycle.
        target_o = flush_i ? new_pc_i : branch_target_i;
        target_o[ALIGN_BITS-1:0] = '0;
        seq_o = cur_addr_i + ADDR_W'(4);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: drives the imem req/ack handshake and one registered IF/ID slot.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              ce_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [ADDR_W-1:0] imem_data_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              busy_q, busy_d;
    logic              ce_q, ce_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic              issue;
    logic              ack;

    assign cur_addr = busy_q ? req_addr_q : pc_q;

    fetch_sequencer_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .flush_i         (flush_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .new_pc_i        (new_pc_i),
        .cur_addr_i      (cur_addr),
        .redirect_o      (redirect),
        .target_o        (target),
        .seq_o           (seq_addr)
    );

    assign issue = (state_q == S_RUN) && !busy_q && !redirect && (!inst_valid_q || !stall_i);
    // An ack only means something while a request is on the bus.
    assign ack   = imem_ack_i && imem_req_o;

    assign imem_req_o   = busy_q | issue;
    assign imem_addr_o  = cur_addr;
    assign ce_o         = ce_q;
    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        busy_d       = busy_q;
        ce_d         = CHIP_ENABLE;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        case (state_q)
            S_RST: state_d = S_RUN;
            S_RUN: begin
                if (inst_valid_q && !stall_i) inst_valid_d = 1'b0;
                if (redirect) begin
                    pc_d         = target;
                    inst_valid_d = 1'b0;
                    // Outstanding request must drain before the new stream starts.
                    if (busy_q) begin
                        if (ack) busy_d  = 1'b0;
                        else     state_d = S_KILL;
                    end
                end else if (ack) begin
                    inst_d       = imem_data_i;
                    inst_pc_d    = cur_addr;
                    inst_valid_d = 1'b1;
                    pc_d         = seq_addr;
                    busy_d       = 1'b0;
                end else if (issue) begin
                    busy_d     = 1'b1;
                    req_addr_d = pc_q;
                end
            end
            S_KILL: begin
                if (redirect) pc_d = target;
                if (ack) begin
                    busy_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= S_RST;
            pc_q         <= RESET_VEC;
            req_addr_q   <= '0;
            busy_q       <= 1'b0;
            ce_q         <= CHIP_DISABLE;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            busy_q       <= busy_d;
            ce_q         <= ce_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push expected requests/instructions.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        ce_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int total = 0;
    int bad   = 0;
    int mem_lat = 0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_inst[$];

    fetch_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .ce_o            (ce_o),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input logic [31:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid_o && inst_pc_o == a) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL wait_slot: timeout, slot %h never seen", a);
        end
    endtask

    // Memory: ack tied high when mem_lat==0, else ack in the mem_lat-th cycle of a request.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_lat == 0) begin
                imem_ack_i = 1'b1;
                wcnt = 0;
            end else if (imem_req_o) begin
                if (wcnt == mem_lat - 1) begin
                    imem_ack_i = 1'b1;
                    wcnt = 0;
                end else begin
                    imem_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                wcnt = 0;
            end
            imem_data_i = mem_word(imem_addr_o);
        end
    end

    // Monitor: accepted requests, consumed slots, and address stability while waiting.
    initial begin
        logic        prev_pend = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_held", {31'b0, imem_req_o}, 32'd1);
                    chk("addr_held", imem_addr_o, prev_addr);
                end
                if (imem_req_o && imem_ack_i) begin
                    if (exp_req.size() == 0) begin
                        total++; bad++;
                        $display("FAIL req_unexpected: got %h want none", imem_addr_o);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_addr", imem_addr_o, e);
                    end
                end
                if (inst_valid_o && !stall_i) begin
                    if (exp_inst.size() == 0) begin
                        total++; bad++;
                        $display("FAIL inst_unexpected: got pc %h want none", inst_pc_o);
                    end else begin
                        e = exp_inst.pop_front();
                        chk("inst_pc", inst_pc_o, e);
                        chk("inst", inst_o, mem_word(e));
                    end
                end
                prev_pend = imem_req_o && !imem_ack_i;
                prev_addr = imem_addr_o;
            end
        end
    end

    initial begin
        // 1: reset for 3 cycles, zero-wait memory
        repeat (3) begin
            step();
            chk("rst_ce", {31'b0, ce_o}, 32'd0);
            chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
            chk("rst_inst", inst_o, 32'h0);
            chk("rst_inst_pc", inst_pc_o, 32'h0);
            chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        end
        foreach (exp_req[i]) exp_req.delete(i);
        exp_req  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_inst = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        rst = 1'b0;
        #1 chk("ce_release_cycle", {31'b0, ce_o}, 32'd0);
        step();
        chk("ce_run", {31'b0, ce_o}, 32'd1);

        // 2: stall with slot 0x10 live
        wait_slot(32'h10);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_req", {31'b0, imem_req_o}, 32'd0);
            chk("stall_pc", inst_pc_o, 32'h10);
            chk("stall_inst", inst_o, mem_word(32'h10));
            step();
        end

        // 3: branch to 0x103 while a 3-cycle request is outstanding
        exp_req.push_back(32'h14);
        exp_req.push_back(32'h100);
        exp_inst.push_back(32'h100);
        stall_i = 1'b0;
        mem_lat = 3;
        step();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h103;
        #1;
        chk("br_addr_held", imem_addr_o, 32'h14);
        chk("br_req_held", {31'b0, imem_req_o}, 32'd1);
        step();
        branch_flag_i = 1'b0;
        #1 chk("kill_addr", imem_addr_o, 32'h14);
        wait_slot(32'h100);

        // 4: flush and branch together, flush wins
        exp_req  = '{32'h20, 32'h24, 32'h28};
        exp_inst.push_back(32'h20);
        exp_inst.push_back(32'h24);
        exp_inst.push_back(32'h28);
        mem_lat = 0;
        flush_i = 1'b1;
        new_pc_i = 32'h20;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h80;
        step();
        flush_i = 1'b0;
        branch_flag_i = 1'b0;
        chk("flush_valid", {31'b0, inst_valid_o}, 32'd0);
        #1 chk("flush_addr", imem_addr_o, 32'h20);
        wait_slot(32'h28);

        // 5: PC wrap at the top of the address space
        exp_req.push_back(32'hFFFF_FFF8);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);
        exp_inst.push_back(32'hFFFF_FFF8);
        exp_inst.push_back(32'hFFFF_FFFC);
        exp_inst.push_back(32'h0);
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFF8;
        step();
        branch_flag_i = 1'b0;
        wait_slot(32'h0);

        // 6: reset while busy, ack lands during reset and must be ignored
        exp_req.push_back(32'h0);
        exp_inst.push_back(32'h0);
        mem_lat = 2;
        step();
        rst = 1'b1;
        step();
        chk("rst_busy_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_busy_ce", {31'b0, ce_o}, 32'd0);
        step();
        rst = 1'b0;
        chk("post_rst_valid", {31'b0, inst_valid_o}, 32'd0);
        wait_slot(32'h0);
        mem_lat = 100;
        repeat (3) step();
        #2;
        chk("req_queue_empty", exp_req.size(), 32'd0);
        chk("inst_queue_empty", exp_inst.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
